// File: rtl/ifns_ft_monitor_18.sv
// Forbidden-transition monitor for the registered IFNS encoder codeword stream.
// Flags adjacent wires switching in opposite directions between consecutive accepted words.
module ifns_ft_monitor_18 #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               code_valid,
    input  logic [WIDTH:1]     codein,
    input  logic               clear,
    output logic               ft_valid,
    output logic               ft_flag,
    output logic [WIDTH-1:1]   ft_mask,
    output logic [CNT_W-1:0]   word_count,
    output logic [CNT_W-1:0]   viol_count,
    output logic               first_hit,
    output logic [CNT_W-1:0]   first_idx
);

    typedef enum logic {
        EMPTY = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t            state;
    logic [WIDTH:1]    prev;

    logic [WIDTH:1]    rise;
    logic [WIDTH:1]    fall;
    logic [WIDTH-1:1]  mask_c;
    logic              viol_c;

    logic [CNT_W-1:0]  wc_base;
    logic [CNT_W-1:0]  vc_base;
    logic [CNT_W-1:0]  idx_base;
    logic              hit_base;
    logic [CNT_W-1:0]  wc_inc;
    logic [CNT_W-1:0]  vc_inc;

    always_comb begin
        rise   = ~prev & codein;
        fall   = prev & ~codein;
        mask_c = '0;
        for (int unsigned k = 1; k < WIDTH; k++) begin
            mask_c[k] = (rise[k] & fall[k+1]) | (fall[k] & rise[k+1]);
        end
        viol_c = |mask_c;
    end

    // clear zeroes the bookkeeping first, so a coincident word counts as the first one
    always_comb begin
        wc_base  = clear ? '0   : word_count;
        vc_base  = clear ? '0   : viol_count;
        idx_base = clear ? '0   : first_idx;
        hit_base = clear ? 1'b0 : first_hit;
        wc_inc   = (wc_base == '1) ? wc_base : wc_base + 1'b1;
        vc_inc   = (vc_base == '1) ? vc_base : vc_base + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= EMPTY;
            prev       <= '0;
            ft_valid   <= 1'b0;
            ft_flag    <= 1'b0;
            ft_mask    <= '0;
            word_count <= '0;
            viol_count <= '0;
            first_hit  <= 1'b0;
            first_idx  <= '0;
        end else begin
            ft_valid   <= 1'b0;
            word_count <= wc_base;
            viol_count <= vc_base;
            first_hit  <= hit_base;
            first_idx  <= idx_base;
            if (code_valid) begin
                word_count <= wc_inc;
                prev       <= codein;
                state      <= ARMED;
                if (state == ARMED) begin
                    ft_valid <= 1'b1;
                    ft_flag  <= viol_c;
                    ft_mask  <= mask_c;
                    if (viol_c) begin
                        viol_count <= vc_inc;
                        if (!hit_base) begin
                            first_hit <= 1'b1;
                            first_idx <= wc_base;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ifns_ft_monitor_18.sv
// Scoreboard bench for ifns_ft_monitor_18: default instance plus a CNT_W=4 instance
// sharing stimulus; per-cycle expectations are queued at drive time and popped on negedge.
module tb_ifns_ft_monitor_18;

    localparam int unsigned WIDTH = 18;

    logic              clock = 1'b0;
    logic              rst;
    logic              code_valid;
    logic [WIDTH:1]    codein;
    logic              clear;

    logic              ft_valid,  ft_flag;
    logic [WIDTH-1:1]  ft_mask;
    logic [15:0]       word_count, viol_count, first_idx;
    logic              first_hit;

    logic              ft_valid4, ft_flag4;
    logic [WIDTH-1:1]  ft_mask4;
    logic [3:0]        word_count4, viol_count4, first_idx4;
    logic              first_hit4;

    ifns_ft_monitor_18 #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clock(clock), .rst(rst), .code_valid(code_valid), .codein(codein), .clear(clear),
        .ft_valid(ft_valid), .ft_flag(ft_flag), .ft_mask(ft_mask),
        .word_count(word_count), .viol_count(viol_count),
        .first_hit(first_hit), .first_idx(first_idx)
    );

    ifns_ft_monitor_18 #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
        .clock(clock), .rst(rst), .code_valid(code_valid), .codein(codein), .clear(clear),
        .ft_valid(ft_valid4), .ft_flag(ft_flag4), .ft_mask(ft_mask4),
        .word_count(word_count4), .viol_count(viol_count4),
        .first_hit(first_hit4), .first_idx(first_idx4)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned valid, flag, mask;
        int unsigned wc, vc, hit, idx;
        int unsigned wc4, vc4, hit4, idx4;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int unsigned    m_armed, m_prev, m_flag, m_mask;
    int unsigned    m_wc, m_vc, m_hit, m_idx;
    int unsigned    m_wc4, m_vc4, m_hit4, m_idx4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // pair k violated when both wires toggle and end at different levels
    function automatic int unsigned ref_mask(input int unsigned a, input int unsigned b);
        int unsigned m = 0;
        for (int k = 0; k < WIDTH - 1; k++) begin
            if (a[k] != b[k] && a[k+1] != b[k+1] && b[k] != b[k+1])
                m |= (32'd1 << k);
        end
        return m;
    endfunction

    function automatic int unsigned sat(input int unsigned x, input int unsigned maxv);
        return (x >= maxv) ? maxv : x + 1;
    endfunction

    task automatic step(input bit r, input bit v, input int unsigned code, input bit clr);
        exp_t e;
        int unsigned mk;
        rst        = r;
        code_valid = v;
        codein     = code[WIDTH-1:0];
        clear      = clr;
        e.valid = 0;
        if (r) begin
            m_armed = 0; m_prev = 0; m_flag = 0; m_mask = 0;
            m_wc = 0; m_vc = 0; m_hit = 0; m_idx = 0;
            m_wc4 = 0; m_vc4 = 0; m_hit4 = 0; m_idx4 = 0;
        end else begin
            if (clr) begin
                m_wc = 0; m_vc = 0; m_hit = 0; m_idx = 0;
                m_wc4 = 0; m_vc4 = 0; m_hit4 = 0; m_idx4 = 0;
            end
            if (v) begin
                if (m_armed != 0) begin
                    mk = ref_mask(m_prev, code);
                    e.valid = 1;
                    m_mask  = mk;
                    m_flag  = (mk != 0) ? 1 : 0;
                    if (m_flag != 0) begin
                        m_vc  = sat(m_vc, 65535);
                        m_vc4 = sat(m_vc4, 15);
                        if (m_hit == 0)  begin m_hit = 1;  m_idx = m_wc;   end
                        if (m_hit4 == 0) begin m_hit4 = 1; m_idx4 = m_wc4; end
                    end
                end
                m_wc    = sat(m_wc, 65535);
                m_wc4   = sat(m_wc4, 15);
                m_prev  = code;
                m_armed = 1;
            end
        end
        e.flag = m_flag; e.mask = m_mask;
        e.wc = m_wc; e.vc = m_vc; e.hit = m_hit; e.idx = m_idx;
        e.wc4 = m_wc4; e.vc4 = m_vc4; e.hit4 = m_hit4; e.idx4 = m_idx4;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ft_valid",   {31'd0, ft_valid},   e.valid);
            check("ft_flag",    {31'd0, ft_flag},    e.flag);
            check("ft_mask",    {15'd0, ft_mask},    e.mask);
            check("word_count", {16'd0, word_count}, e.wc);
            check("viol_count", {16'd0, viol_count}, e.vc);
            check("first_hit",  {31'd0, first_hit},  e.hit);
            check("first_idx",  {16'd0, first_idx},  e.idx);
            check("ft_valid4",  {31'd0, ft_valid4},  e.valid);
            check("ft_mask4",   {15'd0, ft_mask4},   e.mask);
            check("word_cnt4",  {28'd0, word_count4}, e.wc4);
            check("viol_cnt4",  {28'd0, viol_count4}, e.vc4);
            check("first_hit4", {31'd0, first_hit4}, e.hit4);
            check("first_idx4", {28'd0, first_idx4}, e.idx4);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; code_valid = 1'b0; codein = '0; clear = 1'b0;

        // reset state, then a non-violating pair
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_zero", {15'd0, ft_mask} | {16'd0, word_count}, 32'd0);
        step(0, 1, 32'h00000, 0);
        step(0, 1, 32'h00001, 0);
        check("basic_wc", {16'd0, word_count}, 32'd2);
        step(0, 0, 32'h00000, 0);

        // simplest opposite-direction pair
        step(1, 0, 0, 0);
        step(0, 1, 32'h00001, 0);
        step(0, 1, 32'h00002, 0);
        check("pair_mask", {15'd0, ft_mask}, 32'h00001);
        check("pair_idx",  {16'd0, first_idx}, 32'd1);

        // every pair violated, then all-upward switching
        step(1, 0, 0, 0);
        step(0, 1, 32'h15555, 0);
        step(0, 1, 32'h2AAAA, 0);
        check("alt_mask", {15'd0, ft_mask}, 32'h1FFFF);
        step(0, 1, 32'h3FFFF, 0);
        check("up_flag", {31'd0, ft_flag}, 32'd0);

        // saturation on the 4-bit instance
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step(0, 1, (i % 2 == 0) ? 32'h00001 : 32'h00002, 0);
        check("sat_wc4", {28'd0, word_count4}, 32'd15);
        check("sat_vc4", {28'd0, viol_count4}, 32'd15);
        check("sat_wc",  {16'd0, word_count},  32'd20);

        // gap: reference held across idle cycles
        step(1, 0, 0, 0);
        step(0, 1, 32'h00001, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h3FFFF, 0);
        step(0, 1, 32'h00002, 0);
        check("gap_mask", {15'd0, ft_mask}, 32'h00001);

        // clear coinciding with a violating word
        step(1, 0, 0, 0);
        step(0, 1, 32'h00000, 0);
        step(0, 1, 32'h00003, 0);
        step(0, 1, 32'h00007, 0);
        step(0, 1, 32'h0000F, 0);
        step(0, 1, 32'h0001F, 0);
        step(0, 1, 32'h00020, 1);
        check("clr_wc",  {16'd0, word_count}, 32'd1);
        check("clr_vc",  {16'd0, viol_count}, 32'd1);
        check("clr_idx", {16'd0, first_idx},  32'd0);
        step(0, 0, 32'h00000, 1);

        // reset during traffic, then first word only reloads the reference
        step(0, 1, 32'h00001, 0);
        step(1, 1, 32'h00002, 0);
        step(0, 1, 32'h00001, 0);
        check("rst_mid_valid", {31'd0, ft_valid}, 32'd0);
        step(0, 1, 32'h00002, 0);

        // random traffic with gaps and occasional clear
        for (int i = 0; i < 40; i++)
            step(0, ($urandom_range(3) != 0), $urandom_range(32'h3FFFF), ($urandom_range(15) == 0));

        step(0, 0, 0, 0);
        @(negedge clock);
        #1;
        check("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
